cache_direct_mapped: RTL and testbench

CACHE_DIRECT_MAPPED -- requirements
Module: cache_direct_mapped

---
 rtl/cache_pkg.sv | 16 +
 rtl/cache_line_store.sv | 48 ++++
 rtl/cache_direct_mapped.sv | 171 +++++++++++++++++
 tb/tb_cache_direct_mapped.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache: FSM state encoding and default sizes.
package cache_pkg;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_INDEX_W = 4;
    localparam int unsigned DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cache_line_store.sv
// Tag/valid/data array: combinational index read port, one write port, flush-all of valid bits.
module cache_line_store #(
    parameter int unsigned INDEX_W = 4,
    parameter int unsigned TAG_W   = 28,
    parameter int unsigned DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);

    localparam int unsigned LINES = 1 << INDEX_W;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [DATA_W-1:0] data [LINES];

    // Only the valid bits are reset or flushed; tag and data contents persist.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index];

endmodule

// File: rtl/cache_direct_mapped.sv
// Direct-mapped write-through, write-allocate cache with single-word lines and hit/miss statistics.
module cache_direct_mapped
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned INDEX_W = DEF_INDEX_W,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DIN,
    input  logic              FLUSH,
    output logic [DATA_W-1:0] DOUT,
    output logic              RDY,
    output logic              BUSY,
    output logic [ADDR_W-1:0] MADDR,
    output logic [DATA_W-1:0] MDOUT,
    input  logic [DATA_W-1:0] MDIN,
    output logic              MREQ,
    output logic              MWE,
    input  logic              MRDY,
    output logic [CNT_W-1:0]  HIT_CNT,
    output logic [CNT_W-1:0]  MISS_CNT
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W;

    state_t state, state_next;

    logic we_r;
    logic hit_r;
    logic acc_r;

    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [DATA_W-1:0]  rd_data;
    logic [INDEX_W-1:0] rd_index_c;
    logic               hit_c;
    logic               accept_c;
    logic               flush_c;
    logic               store_we_c;
    logic [DATA_W-1:0]  store_wdata_c;

    // Lookup uses the live address while idle, the captured request (MADDR) otherwise.
    assign rd_index_c = (state == IDLE) ? ADDR[INDEX_W-1:0] : MADDR[INDEX_W-1:0];
    assign hit_c      = rd_valid && (rd_tag == ADDR[ADDR_W-1:INDEX_W]);

    cache_line_store #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_store (
        .clk      (CLK),
        .rst      (RST),
        .flush    (flush_c),
        .rd_index (rd_index_c),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (store_we_c),
        .wr_index (MADDR[INDEX_W-1:0]),
        .wr_tag   (MADDR[ADDR_W-1:INDEX_W]),
        .wr_data  (store_wdata_c)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        accept_c      = 1'b0;
        flush_c       = 1'b0;
        store_we_c    = 1'b0;
        store_wdata_c = MDIN;
        case (state)
            IDLE: begin
                flush_c = FLUSH;
                if (REQ && !FLUSH) begin
                    accept_c = 1'b1;
                    if (WE) begin
                        state_next = WRITE;
                    end else if (hit_c) begin
                        state_next = DONE;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                if (MRDY) begin
                    store_we_c = 1'b1;
                    state_next = DONE;
                end
            end
            WRITE: begin
                if (MRDY) begin
                    store_we_c    = 1'b1;
                    store_wdata_c = MDOUT;
                    state_next    = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // A reset coinciding with MRDY discards the returned word.
        if (RST) begin
            store_we_c = 1'b0;
        end
    end

    // Registered outputs; MADDR/MDOUT double as the captured request address/data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DOUT     <= '0;
            RDY      <= 1'b0;
            BUSY     <= 1'b0;
            MADDR    <= '0;
            MDOUT    <= '0;
            MREQ     <= 1'b0;
            MWE      <= 1'b0;
            HIT_CNT  <= '0;
            MISS_CNT <= '0;
            we_r     <= 1'b0;
            hit_r    <= 1'b0;
            acc_r    <= 1'b0;
        end else begin
            RDY   <= (state == DONE);
            BUSY  <= (state_next != IDLE);
            MREQ  <= (state_next == FILL) || (state_next == WRITE);
            MWE   <= (state_next == WRITE);
            acc_r <= accept_c;
            if (state == DONE) begin
                DOUT <= we_r ? '0 : rd_data;
            end
            if (accept_c) begin
                we_r  <= WE;
                hit_r <= hit_c;
                MADDR <= ADDR;
                if (WE) begin
                    MDOUT <= DIN;
                end
            end
            // Statistics are booked the cycle after acceptance from the registered hit result.
            if (acc_r) begin
                if (hit_r) begin
                    if (HIT_CNT != {CNT_W{1'b1}}) begin
                        HIT_CNT <= HIT_CNT + CNT_W'(1);
                    end
                end else begin
                    if (MISS_CNT != {CNT_W{1'b1}}) begin
                        MISS_CNT <= MISS_CNT + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_direct_mapped.sv
// Self-checking bench: directed table, hand-written corner sequences and randomized traffic vs a reference model.
module tb_cache_direct_mapped;

    logic        CLK = 1'b0;
    logic        RST, REQ, WE, FLUSH, MRDY;
    logic [31:0] ADDR, DIN, MDIN;

    logic [31:0] DOUT, MADDR, MDOUT;
    logic        RDY, BUSY, MREQ, MWE;
    logic [15:0] HIT_CNT, MISS_CNT;

    logic [31:0] d1_dout, d1_maddr, d1_mdout;
    logic        d1_rdy, d1_busy, d1_mreq, d1_mwe;
    logic [1:0]  d1_hit_cnt, d1_miss_cnt;

    cache_direct_mapped dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .DIN(DIN), .FLUSH(FLUSH),
        .DOUT(DOUT), .RDY(RDY), .BUSY(BUSY), .MADDR(MADDR), .MDOUT(MDOUT), .MDIN(MDIN),
        .MREQ(MREQ), .MWE(MWE), .MRDY(MRDY), .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT)
    );

    // Narrow-counter copy driven by the same stimulus, used for saturation checks.
    cache_direct_mapped #(.CNT_W(2)) dut_sat (
        .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .DIN(DIN), .FLUSH(FLUSH),
        .DOUT(d1_dout), .RDY(d1_rdy), .BUSY(d1_busy), .MADDR(d1_maddr), .MDOUT(d1_mdout), .MDIN(MDIN),
        .MREQ(d1_mreq), .MWE(d1_mwe), .MRDY(MRDY), .HIT_CNT(d1_hit_cnt), .MISS_CNT(d1_miss_cnt)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: backing memory plus a 16-line view of which words the cache holds.
    logic [31:0] mem [logic [31:0]];
    bit          mvalid [16];
    logic [31:0] mtag   [16];
    int unsigned hits, misses;

    function automatic logic [31:0] memrd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return mvalid[a % 16] && (mtag[a % 16] == a / 16);
    endfunction

    function automatic logic [63:0] sat(input int unsigned c, input int unsigned m);
        return (c > m) ? 64'(m) : 64'(c);
    endfunction

    task automatic model_flush();
        foreach (mvalid[i]) mvalid[i] = 1'b0;
    endtask

    task automatic model_reset();
        model_flush();
        hits   = 0;
        misses = 0;
    endtask

    task automatic check_counters(input string lbl);
        chk({lbl, " hit_cnt"},  64'(HIT_CNT),     sat(hits, 65535));
        chk({lbl, " miss_cnt"}, 64'(MISS_CNT),    sat(misses, 65535));
        chk({lbl, " sat_hit"},  64'(d1_hit_cnt),  sat(hits, 3));
        chk({lbl, " sat_miss"}, 64'(d1_miss_cnt), sat(misses, 3));
    endtask

    // One request with a memory that answers on the lat-th MREQ cycle; noise pokes REQ/FLUSH/MRDY while busy.
    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d, input int lat,
                          input bit noise, input bit exp_hit, input logic [31:0] exp_dout, input string lbl);
        int nreq, n, rdy_at, exp_nreq;
        bit port_ok;
        logic [31:0] got;
        if (we) mem[a] = d;
        exp_nreq = (!we && exp_hit) ? 0 : lat;
        REQ = 1'b1; WE = we; ADDR = a; DIN = d; FLUSH = 1'b0;
        step();
        REQ = 1'b0;
        n = 1; nreq = 0; rdy_at = -1; port_ok = 1'b1; got = '0;
        while (n < 60 && rdy_at < 0) begin
            MRDY = 1'b0; REQ = 1'b0; FLUSH = 1'b0; MDIN = $urandom;
            if (MREQ) begin
                nreq++;
                if (MADDR !== a || MWE !== we || (we && MDOUT !== d)) port_ok = 1'b0;
                if (nreq == lat) begin
                    MRDY = 1'b1;
                    MDIN = memrd(a);
                end
            end else if (noise) begin
                MRDY = 1'($urandom_range(0, 1));
            end
            if (RDY) begin
                rdy_at = n;
                got = DOUT;
                chk({lbl, " busy_at_rdy"}, 64'(BUSY), 64'd0);
            end else if (noise && BUSY) begin
                REQ = 1'($urandom_range(0, 1)); WE = 1'($urandom_range(0, 1));
                ADDR = $urandom; DIN = $urandom; FLUSH = 1'($urandom_range(0, 1));
            end
            if (rdy_at < 0) begin
                step();
                n++;
            end
        end
        MRDY = 1'b0; REQ = 1'b0; FLUSH = 1'b0;
        if (rdy_at < 0) begin
            chk({lbl, " rdy_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({lbl, " dout"}, 64'(got), 64'(exp_dout));
            chk({lbl, " latency"}, 64'(rdy_at), 64'((exp_nreq == 0) ? 2 : lat + 2));
        end
        chk({lbl, " mreq_cycles"}, 64'(nreq), 64'(exp_nreq));
        chk({lbl, " mem_port"}, 64'(port_ok), 64'd1);
        if (exp_hit) hits++; else misses++;
        mvalid[a % 16] = 1'b1;
        mtag[a % 16]   = a / 16;
        check_counters(lbl);
    endtask

    // FLUSH in an idle cycle, optionally with a competing REQ that must be dropped.
    task automatic flush_req(input logic [31:0] a, input bit with_req, input string lbl);
        bit saw_rdy, saw_busy;
        FLUSH = 1'b1; REQ = with_req; WE = 1'b0; ADDR = a;
        step();
        FLUSH = 1'b0; REQ = 1'b0;
        model_flush();
        saw_rdy = 1'b0; saw_busy = 1'b0;
        repeat (4) begin
            if (RDY) saw_rdy = 1'b1;
            if (BUSY || MREQ) saw_busy = 1'b1;
            step();
        end
        chk({lbl, " no_rdy"}, 64'(saw_rdy), 64'd0);
        chk({lbl, " no_busy"}, 64'(saw_busy), 64'd0);
        check_counters(lbl);
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] din;
        int          lat;
        bit          hit;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int n;
        bit saw_rdy, saw_busy;
        logic [31:0] a;
        bit w;

        tbl[0] = '{1'b0, 32'h0000_0010, 32'h0,         3, 1'b0, 32'hDEAD_BEEF};
        tbl[1] = '{1'b0, 32'h0000_0010, 32'h0,         3, 1'b1, 32'hDEAD_BEEF};
        tbl[2] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 2, 1'b0, 32'h0};
        tbl[3] = '{1'b0, 32'h0000_0010, 32'h0,         1, 1'b0, 32'hDEAD_BEEF};
        tbl[4] = '{1'b0, 32'h0000_0020, 32'h0,         1, 1'b0, 32'h1234_5678};
        tbl[5] = '{1'b0, 32'h0000_0020, 32'h0,         2, 1'b1, 32'h1234_5678};
        mem[32'h0000_0010] = 32'hDEAD_BEEF;

        RST = 1'b1; REQ = 1'b0; WE = 1'b0; FLUSH = 1'b0; MRDY = 1'b0;
        ADDR = '0; DIN = '0; MDIN = '0;
        step();
        step();
        chk("reset rdy",   64'(RDY),   64'd0);
        chk("reset busy",  64'(BUSY),  64'd0);
        chk("reset mreq",  64'({MREQ, MWE}), 64'd0);
        chk("reset dout",  64'(DOUT),  64'd0);
        chk("reset maddr", 64'(MADDR), 64'd0);
        chk("reset mdout", 64'(MDOUT), 64'd0);
        RST = 1'b0;
        model_reset();
        check_counters("reset");

        foreach (tbl[i])
            access(tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].lat, 1'b0, tbl[i].hit, tbl[i].dout,
                   $sformatf("vec%0d", i));

        // FLUSH wins over REQ; the flushed line must then miss.
        flush_req(32'h0000_0020, 1'b1, "flush_req");
        access(1'b0, 32'h0000_0020, 32'h0, 2, 1'b0, 1'b0, 32'h1234_5678, "after_flush");

        // Reset in the same cycle as MRDY during a fill.
        REQ = 1'b1; WE = 1'b0; ADDR = 32'h0000_0030;
        step();
        REQ = 1'b0;
        n = 0;
        while (!MREQ && n < 10) begin
            step();
            n++;
        end
        chk("rst_fill mreq_seen", 64'(MREQ), 64'd1);
        MRDY = 1'b1; MDIN = 32'hCAFE_F00D; RST = 1'b1;
        step();
        RST = 1'b0; MRDY = 1'b0;
        model_reset();
        saw_rdy = 1'b0; saw_busy = 1'b0;
        repeat (4) begin
            if (RDY) saw_rdy = 1'b1;
            if (BUSY || MREQ || MWE) saw_busy = 1'b1;
            step();
        end
        chk("rst_fill no_rdy", 64'(saw_rdy), 64'd0);
        chk("rst_fill idle", 64'(saw_busy), 64'd0);
        check_counters("rst_fill");
        access(1'b0, 32'h0000_0030, 32'h0, 2, 1'b0, 1'b0, memrd(32'h0000_0030), "rst_fill reread");

        // Five hits: narrow counter pins at 3, wide counter keeps counting.
        for (int i = 0; i < 5; i++)
            access(1'b0, 32'h0000_0030, 32'h0, 1, 1'b0, 1'b1, memrd(32'h0000_0030), $sformatf("sat%0d", i));
        chk("sat hit_cnt_2bit", 64'(d1_hit_cnt), 64'd3);
        chk("sat hit_cnt_16bit", 64'(HIT_CNT), 64'd5);

        // Randomized traffic with busy-time noise against the model.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                flush_req(32'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), $sformatf("rflush%0d", i));
            end else begin
                if ($urandom_range(0, 15) == 0) a = $urandom;
                else a = 32'($urandom_range(0, 3) * 16 + $urandom_range(0, 15));
                w = ($urandom_range(0, 9) < 3);
                access(w, a, $urandom, $urandom_range(1, 4), 1'b1, model_hit(a),
                       w ? 32'h0 : memrd(a), $sformatf("rand%0d", i));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
